// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the round-robin multiplier scheduler.
package mult_sched_pkg;
  localparam int OP_W     = 16;
  localparam int PROD_W   = 32;
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [PROD_W-1:0]   product;
  } stage_t;
endpackage

// File: rtl/mult_16x16_pipe.sv
// LAT-deep unsigned 16x16 multiply pipeline carrying {valid, id, product};
// all stages advance together on en.
module mult_16x16_pipe
  import mult_sched_pkg::*;
#(
  parameter int LAT = 2,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in_valid,
  input  logic [IDW-1:0]  in_id,
  input  logic [OP_W-1:0] in_a,
  input  logic [OP_W-1:0] in_b,
  output stage_t          out_stage
);

  stage_t stg_p [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) stg_p[i] <= '0;
    end else if (en) begin
      // stage 0: multiply and tag
      stg_p[0].valid   <= in_valid;
      stg_p[0].id      <= ID_MAX_W'(in_id);
      stg_p[0].product <= PROD_W'(in_a) * PROD_W'(in_b);
      // stages 1..LAT-1: plain delay, the last one is the response register
      for (int i = 1; i < LAT; i++) stg_p[i] <= stg_p[i-1];
    end
  end

  assign out_stage = stg_p[LAT-1];

endmodule

// File: rtl/mult_16x16_rr_sched.sv
// Round-robin scheduler sharing one pipelined 16x16 multiplier among NREQ requesters.
// Optional MULT_ARB_PERF_EN adds busy_cnt / stall_cnt performance counters.
module mult_16x16_rr_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [PROD_W-1:0]    rsp_product
`ifdef MULT_ARB_PERF_EN
  ,
  output logic [31:0]          busy_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  logic            stall;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  scan_id;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [NREQ-1:0] gnt;
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  stage_t          pipe_out;
  logic            unused_id_bits;

  function automatic logic [IDW-1:0] rr_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  assign stall = rsp_valid & ~rsp_ready;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    scan_id = '0;
    if (!stall) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_id = rr_add(rr_ptr, k);
        if (!gnt_any && req_valid[scan_id]) begin
          gnt_any      = 1'b1;
          gnt_id       = scan_id;
          gnt[scan_id] = 1'b1;
        end
      end
    end
  end

  assign req_ready = rst_n ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= rr_add(gnt_id, 1);
  end

  assign op_a = req_a[int'(gnt_id)*OP_W +: OP_W];
  assign op_b = req_b[int'(gnt_id)*OP_W +: OP_W];

  mult_16x16_pipe #(
    .LAT (LAT),
    .IDW (IDW)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (~stall),
    .in_valid  (gnt_any),
    .in_id     (gnt_id),
    .in_a      (op_a),
    .in_b      (op_b),
    .out_stage (pipe_out)
  );

  assign rsp_valid   = pipe_out.valid;
  assign rsp_id      = pipe_out.id[IDW-1:0];
  assign rsp_product = pipe_out.product;
  // tag field is sized for the largest NREQ; high bits are always zero here
  assign unused_id_bits = ^pipe_out.id;

`ifdef MULT_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (gnt_any) busy_cnt  <= busy_cnt + 32'd1;
      if (stall)   stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mult_16x16_rr_sched.md
# mult_16x16_rr_sched

Round-robin scheduler that shares one pipelined 16x16 unsigned multiplier among NREQ requesters. Each requester presents operands with a valid/ready handshake. The block grants at most one request per cycle, pushes it through a LAT-stage multiply pipeline tagged with the requester index, and returns the 32-bit product on a single backpressured response port. It sits between the multiplier datapath and the client blocks that need products.

## Interface
- NREQ, 4: number of requesters (2..8)
- LAT, 2: multiply pipeline depth in cycles (1..4); the last stage is the response register
- IDW, $clog2(NREQ): width of the requester tag
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request i has operands
- req_ready  out  NREQ  one-hot grant; a transfer occurs on req_valid[i] & req_ready[i]
- req_a  in  NREQ*16  operand a, requester i at [16i+15:16i]
- req_b  in  NREQ*16  operand b, same packing
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  IDW  index of the requester that owns rsp_product
- rsp_product  out  32  a*b, unsigned
- busy_cnt  out  32  present only with MULT_ARB_PERF_EN
- stall_cnt  out  32  present only with MULT_ARB_PERF_EN

## Operation
- stall = rsp_valid & ~rsp_ready. While stall is high, every pipeline stage holds its contents and req_ready is all zero.
- When stall is low, the arbiter scans requesters starting at rr_ptr in increasing index order, wrapping modulo NREQ. The first i with req_valid[i] high receives req_ready[i] = 1 in the same cycle (combinational).
- req_ready depends on req_valid and stall only. It must not depend on req_a or req_b.
- Pointer update: on a grant to requester i, rr_ptr <= (i+1) mod NREQ. With no grant, rr_ptr holds.
- Product: full 32-bit unsigned a*b with no truncation. 0xFFFF*0xFFFF = 0xFFFE0001.
- Each pipeline stage carries {valid, id, product}. Bubbles propagate as valid = 0.
- A response is consumed when rsp_valid & rsp_ready. If no new entry reaches the last stage in that cycle, rsp_valid drops.
- Responses leave in grant order. No reordering.
- Reset (asynchronous, any time, including mid-pipeline):
  - all stage valids = 0, rsp_valid = 0, rsp_id = 0, rsp_product = 0, rr_ptr = 0
  - req_ready = 0 while rst_n is low
  - in-flight products are discarded
- Release from reset: the first grant goes to the lowest-index valid requester.

## Timing
- Latency: a request accepted at edge t presents rsp_valid at edge t+LAT when there are no stalls. Each stall cycle adds one cycle.
- Throughput: one product per cycle while rsp_ready is held high.
- rsp_id, rsp_product and rsp_valid are registered outputs. They stay stable while stall is high.
- Simultaneous events:
  - accept-on-output and a new grant in the same cycle is legal; the pipeline advances by one.
  - a requester dropping req_valid in the cycle it would have been granted simply gets no grant; it is not a protocol error.

## Configuration
- MULT_ARB_PERF_EN defined:
  - busy_cnt increments on every cycle with a grant.
  - stall_cnt increments on every cycle with stall high.
  - Both reset to 0 and wrap at 2^32.
- MULT_ARB_PERF_EN undefined: the counters and their ports do not exist. All other behaviour is identical.

## Structure
- Shared package mult_sched_pkg holds:
  - the stage record typedef {valid, id, product}
  - the localparams PROD_W = 32 and OP_W = 16
- One sub-module, mult_16x16_pipe:
  - operands and tag in, LAT register stages with a common enable (~stall)
  - {valid, id, product} out
- The scheduler owns the arbitration, rr_ptr and stall logic.

## Test plan
- Single request: req 2 sends a=3, b=5 with rsp_ready=1 -> rsp_valid after LAT cycles, rsp_id=2, rsp_product=15.
- Extremes: a=0xFFFF, b=0xFFFF -> 0xFFFE0001; a=0, b=0xFFFF -> 0. Results are back-to-back on consecutive cycles.
- Fairness: all four requesters hold valid with rsp_ready=1 -> grant sequence 0,1,2,3,0,1 and rsp_id in the same order, one per cycle.
- Backpressure: rsp_ready low for 3 cycles with the pipeline full:
  - rsp_valid, rsp_id and rsp_product hold
  - req_ready = 0 throughout
  - on release, no entry is lost or duplicated
- Reset mid-operation: assert rst_n low with LAT entries in flight -> rsp_valid=0 immediately. After release, the first grant goes to the lowest valid index and no stale products appear.
- With MULT_ARB_PERF_EN: 10 grant cycles plus 3 stall cycles -> busy_cnt=10, stall_cnt=3.
